// File: rtl/passcode_pkg.sv
// passcode_pkg: shared widths, FSM state encoding and key decode for the passcode checker
package passcode_pkg;
  localparam int DIGIT_W  = 2;
  localparam int CODE_LEN = 4;
  localparam int CODE_W   = DIGIT_W * CODE_LEN;
  localparam int BTN_W    = 1 << DIGIT_W;
  localparam logic [2:0] S_Idle    = 3'd0;
  localparam logic [2:0] S_Entry   = 3'd1;
  localparam logic [2:0] S_Check   = 3'd2;
  localparam logic [2:0] S_Unlock  = 3'd3;
  localparam logic [2:0] S_Fail    = 3'd4;
  localparam logic [2:0] S_Lockout = 3'd5;
  // Only meaningful for one-hot keys; multi-key presses are flagged separately.
  function automatic logic [DIGIT_W-1:0] btn_digit(input logic [BTN_W-1:0] b);
    return b[3] ? 2'd3 : b[2] ? 2'd2 : b[1] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: loadable down-counter; done marks the final cycle of a loaded interval
module cycle_timer #(
  parameter int W = 6
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge Clk)
    if (!Rst) r_cnt <= '0;
    else if (i_en) r_cnt <= i_load ? i_val : (r_cnt != '0 ? r_cnt - 1'b1 : r_cnt);
  assign o_done = r_cnt <= W'(1);
endmodule

// File: rtl/passcode_checker.sv
// passcode_checker: four-digit keypad lock with timed unlock, failure lockout and entry timeout
module passcode_checker
  import passcode_pkg::*;
#(
  parameter logic [CODE_W-1:0] CODE = 8'b10_00_11_01,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int MAX_FAIL       = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [BTN_W-1:0] Btn_pulse,
  output logic             Unlock,
  output logic             Err,
  output logic             Locked_out,
  output logic [2:0]       Digit_cnt
);
  localparam int UL_MAX = UNLOCK_CYCLES > LOCKOUT_CYCLES ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int T_MAX  = UL_MAX > TIMEOUT_CYCLES ? UL_MAX : TIMEOUT_CYCLES;
  localparam int TW     = $clog2(T_MAX + 1);
  localparam int FW     = $clog2(MAX_FAIL + 1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
  logic [2:0]         r_state, w_next;
  logic [2:0]         r_cnt;
  logic               r_mis;
  logic [FW-1:0]      r_fail;
  logic               w_press, w_bad, w_load, w_done;
  logic [TW-1:0]      w_val;
  logic [CODE_W-1:0]  w_code_sh;
  assign w_press   = En && Btn_pulse != '0;
  // Shift the stored code so the slot for the next digit sits at the top.
  assign w_code_sh = CODE << {r_cnt, 1'b0};
  assign w_bad     = !$onehot(Btn_pulse) || btn_digit(Btn_pulse) != w_code_sh[CODE_W-1 -: DIGIT_W];
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_Idle:    w_next = w_press ? S_Entry : S_Idle;
      S_Entry:   w_next = w_press ? (r_cnt == 3'(CODE_LEN - 1) ? S_Check : S_Entry)
                                  : (w_done ? S_Idle : S_Entry);
      S_Check:   w_next = r_mis ? S_Fail : S_Unlock;
      S_Unlock:  w_next = w_done ? S_Idle : S_Unlock;
      S_Fail:    w_next = r_fail >= FAIL_LAST ? S_Lockout : S_Idle;
      S_Lockout: w_next = w_done ? S_Idle : S_Lockout;
      default:   w_next = S_Idle;
    endcase
  end
  // One timer serves all three intervals; every state change reloads it.
  assign w_load = w_next != r_state || (r_state == S_Entry && w_press);
  assign w_val  = w_next == S_Entry   ? TW'(TIMEOUT_CYCLES) :
                  w_next == S_Unlock  ? TW'(UNLOCK_CYCLES)  :
                  w_next == S_Lockout ? TW'(LOCKOUT_CYCLES) : '0;
  cycle_timer #(.W(TW)) u_timer (
    .Clk    (Clk),
    .Rst    (Rst),
    .i_en   (En),
    .i_load (w_load),
    .i_val  (w_val),
    .o_done (w_done)
  );
  always_ff @(posedge Clk)
    if (!Rst) begin
      r_state <= S_Idle;
      r_cnt   <= '0;
      r_mis   <= 1'b0;
      r_fail  <= '0;
    end else if (En) begin
      r_state <= w_next;
      if (w_next == S_Idle) begin
        r_cnt <= '0;
        r_mis <= 1'b0;
      end else if (w_press && (r_state == S_Idle || r_state == S_Entry)) begin
        r_cnt <= r_cnt + 3'd1;
        r_mis <= r_mis | w_bad;
      end
      if (r_state == S_Fail && r_fail != FAIL_MAX) r_fail <= r_fail + 1'b1;
      else if (w_next == S_Unlock || (r_state == S_Lockout && w_next == S_Idle)) r_fail <= '0;
    end
  assign Unlock     = r_state == S_Unlock;
  assign Err        = r_state == S_Fail;
  assign Locked_out = r_state == S_Lockout;
  assign Digit_cnt  = r_cnt;
endmodule

// File: tb/tb_passcode_checker.sv
// tb_passcode_checker: constant vector table, scripted corner cases and random traffic vs a queue-based model
module tb_passcode_checker;
  localparam logic [7:0] CODE = 8'b10_00_11_01;
  localparam int UC = 8, LC = 16, TC = 32, MF = 3;
  logic       Clk = 1'b0, Rst = 1'b0, En = 1'b0;
  logic [3:0] Btn_pulse = '0;
  logic       Unlock, Err, Locked_out;
  logic [2:0] Digit_cnt;
  int n_vec = 0, n_bad = 0;
  passcode_checker dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .En         (En),
    .Btn_pulse  (Btn_pulse),
    .Unlock     (Unlock),
    .Err        (Err),
    .Locked_out (Locked_out),
    .Digit_cnt  (Digit_cnt)
  );
  always #5 Clk = ~Clk;
  // Reference: digits typed so far in a queue plus remaining-cycle counts per interval.
  int q[$];
  int idle_run = 0, unlock_left = 0, lock_left = 0, fails = 0;
  bit check = 0, err_now = 0;
  function automatic int code_digit(input int i);
    logic [7:0] c;
    c = CODE >> (6 - 2 * i);
    return int'(c[1:0]);
  endfunction
  function automatic bit code_ok();
    foreach (q[i]) if (q[i] != code_digit(i)) return 0;
    return 1;
  endfunction
  task automatic model_step(input bit r, input bit e, input logic [3:0] b);
    if (!r) begin
      q.delete(); idle_run = 0; unlock_left = 0; lock_left = 0; fails = 0; check = 0; err_now = 0;
    end else if (e) begin
      if (err_now) begin
        err_now = 0;
        if (fails >= MF) lock_left = LC; else q.delete();
      end else if (unlock_left > 0) begin
        unlock_left--;
        if (unlock_left == 0) q.delete();
      end else if (lock_left > 0) begin
        lock_left--;
        if (lock_left == 0) begin fails = 0; q.delete(); end
      end else if (check) begin
        check = 0;
        if (code_ok()) begin unlock_left = UC; fails = 0; end
        else begin err_now = 1; fails++; end
      end else if (b != 0) begin
        q.push_back($onehot(b) ? $clog2(b) : -1);
        idle_run = 0;
        check = q.size() == 4;
      end else if (q.size() != 0) begin
        idle_run++;
        if (idle_run == TC) begin q.delete(); idle_run = 0; end
      end
    end
  endtask
  task automatic cmp(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got {unlock,err,lock,cnt}=%b, expected %b", name, $time, act, exp);
    end
  endtask
  function automatic logic [5:0] outs();
    return {Unlock, Err, Locked_out, Digit_cnt};
  endfunction
  task automatic cyc(input bit r, input bit e, input logic [3:0] b);
    Rst = r; En = e; Btn_pulse = b;
    @(posedge Clk);
    model_step(r, e, b);
    #1;
    cmp("model", outs(), {unlock_left > 0, err_now, lock_left > 0, 3'(q.size())});
  endtask
  task automatic press(input int d);
    cyc(1, 1, 4'(1 << d));
  endtask
  task automatic enter(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 4'b0);
  endtask
  typedef struct { bit r; bit e; logic [3:0] b; logic [5:0] exp; } vec_t;
  vec_t tbl[$];
  task automatic add(input bit r, input bit e, input logic [3:0] b, input logic [5:0] exp);
    vec_t v;
    v.r = r; v.e = e; v.b = b; v.exp = exp;
    tbl.push_back(v);
  endtask
  initial begin
    add(0, 1, 4'b0000, 6'b000_000);
    add(1, 1, 4'b0100, 6'b000_001);
    add(1, 1, 4'b0001, 6'b000_010);
    add(1, 1, 4'b1000, 6'b000_011);
    add(1, 1, 4'b0010, 6'b000_100);
    for (int i = 0; i < UC; i++) add(1, 1, 4'b0000, 6'b100_100);
    add(1, 1, 4'b0000, 6'b000_000);
    add(1, 1, 4'b0100, 6'b000_001);
    add(1, 1, 4'b0001, 6'b000_010);
    add(1, 1, 4'b1000, 6'b000_011);
    add(1, 1, 4'b0100, 6'b000_100);
    add(1, 1, 4'b0000, 6'b010_100);
    add(1, 1, 4'b0000, 6'b000_000);
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].e, tbl[i].b);
      cmp("table", outs(), tbl[i].exp);
    end
    cyc(0, 1, 4'b0);
    for (int k = 0; k < MF; k++) begin
      enter(2, 0, 3, 2);
      idle(1);
      cmp("lockout_err", outs(), 6'b010_100);
      idle(1);
      cmp("lockout_after_fail", outs(), k == MF - 1 ? 6'b001_100 : 6'b000_000);
    end
    enter(2, 0, 3, 1);
    cmp("lockout_ignores_code", outs(), 6'b001_100);
    idle(LC - 5);
    cmp("lockout_last_cycle", outs(), 6'b001_100);
    idle(1);
    cmp("lockout_end", outs(), 6'b000_000);
    enter(2, 0, 3, 1);
    idle(1);
    cmp("unlock_after_lockout", outs(), 6'b100_100);
    idle(UC + 1);
    press(2); press(0);
    idle(TC - 1);
    cmp("timeout_not_yet", outs(), 6'b000_010);
    idle(1);
    cmp("timeout_fired", outs(), 6'b000_000);
    idle(2);
    cmp("timeout_no_err", outs(), 6'b000_000);
    cyc(1, 1, 4'b0101); press(0); press(3); press(1);
    idle(1);
    cmp("invalid_digit_err", outs(), 6'b010_100);
    idle(1);
    press(2); press(0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 4'($urandom_range(0, 15)));
    cmp("enable_hold", outs(), 6'b000_010);
    press(3); press(1);
    idle(1);
    cmp("enable_unlock", outs(), 6'b100_100);
    idle(3);
    cyc(0, 1, 4'b0);
    cmp("reset_mid_unlock", outs(), 6'b000_000);
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [3:0] b;
      r = int'($urandom_range(0, 99));
      b = r < 55 ? 4'b0 : r < 90 ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      if (i % 150 == 0) enter(2, 0, 3, 1);
      else cyc($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0, b);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
